resized_crop_stream: RTL
========================

Name: resized_crop_stream

Overview:
- Consumer of the crop LFSR's random scale code: performs a random resized crop on a raster pixel stream.
- Per frame: latches scale code and offsets, selects a square crop window, nearest-neighbour downsamples it to OUT_SIZE x OUT_SIZE.
- Pulses rnd_advance_o once per finished frame so the LFSR steps to the next random value.
- Sits between the image source (camera/DMA stream) and the augmentation/training input path.

Parameters:
- IMG_SIZE, 28: input image width = height, pixels.
- OUT_SIZE, 16: output width = height; must be <= smallest crop size.
- DATA_W, 8: pixel width, bits.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- scale_i  in  2  random crop-size code (from LFSR).
- off_x_i  in  5  requested crop x offset.
- off_y_i  in  5  requested crop y offset.
- rnd_advance_o  out  1  one-cycle pulse: frame done, advance LFSR.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid & s_ready.
- s_data  in  DATA_W  input pixel, raster order.
- s_last  in  1  marks the final pixel of the input frame.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_W  output pixel.
- m_last  out  1  marks the final output pixel (row OUT_SIZE-1, col OUT_SIZE-1).
- frame_err_o  out  1  one-cycle pulse: s_last mismatch with pixel count.

Behaviour:
- Crop size table, indexed by scale_i: 0->28, 1->24, 2->20, 3->16.
- FSM states: LATCH, RUN, ADV. Reset state is LATCH.
- LATCH (1 cycle, s_ready=0):
  - Register crop = table[scale_i].
  - ox = min(off_x_i, IMG_SIZE-crop); oy likewise from off_y_i.
  - Clear x/y counters and both accumulators; go to RUN.
- RUN:
  - s_ready = !m_valid | m_ready (single output register, no skid buffer).
  - Every accepted pixel advances x; on x wrap (IMG_SIZE-1 -> 0), y advances.
  - A pixel lies in the window iff ox<=x<ox+crop and oy<=y<oy+crop.
- Column selection, per in-window pixel:
  - If cacc+OUT_SIZE >= crop: keep the column, cacc <= cacc+OUT_SIZE-crop.
  - Else: cacc <= cacc+OUT_SIZE.
  - cacc clears at each row start.
- Row selection: same rule with racc, evaluated once per in-window row at x==ox.
- Result: exactly OUT_SIZE rows x OUT_SIZE columns kept; the last window row and column are always kept.
- Output:
  - A pixel kept in both row and column loads the output register: m_valid=1.
  - Output register holds until m_ready. Latency is 1 cycle from accept.
  - Non-kept pixels are consumed and dropped.
- End of frame:
  - Normal end: pixel (IMG_SIZE-1, IMG_SIZE-1) accepted with s_last=1 -> ADV.
  - s_last=1 on any other pixel, or s_last=0 on the final pixel: frame_err_o pulses, frame terminates -> ADV.
  - On early termination the remaining outputs are not produced; m_last is not forced.
- ADV (1 cycle, s_ready=0): rnd_advance_o=1, then LATCH. LATCH therefore samples the LFSR's updated value.
- A pending m_valid may drain during ADV and LATCH.
- Reset values: state=LATCH; m_valid, m_last, m_data, rnd_advance_o, frame_err_o = 0; all counters and accumulators = 0.
- Reset mid-frame discards all state; the next accepted pixel is treated as (0,0).
- Width rules: accumulators are $clog2(2*IMG_SIZE) bits; x, y, ox, oy are $clog2(IMG_SIZE) bits; comparisons unsigned.

Decomposition:
- Package resized_crop_pkg holds: the state enum, the CROP_SIZE[4] table constant, and a derived ACC_W constant.
- Sub-module crop_axis_sel holds one window+accumulator keep-selector (offset, crop, position, step -> keep). It is instantiated twice, once for columns and once for rows.

Test Plan:
- Crop size 16 path: scale=3, off=(0,0), pixel=(y*28+x) mod 256, m_ready=1 -> 256 outputs.
  - First m_data=0, last m_data=179 with m_last=1.
  - rnd_advance_o pulses exactly once, 1 cycle after the final input.
- Full-image crop with offset clamping: scale=0, off=(5,9) -> offsets clamp to 0.
  - Kept columns/rows are 1,3,5,6,...,27; first output=29, 256 outputs total.
- Offset window and backpressure: scale=2, off=(8,8) (crop 20, clamp to 8).
  - Toggle m_ready low for 10 cycles mid-frame -> s_ready low during the stall.
  - No pixel lost or duplicated; output matches the reference model.
- s_last mismatch: s_last early at pixel 100 -> frame_err_o pulse, ADV pulse, then a new frame latches correctly.
  - s_last missing on the final pixel -> same response.
- Reset mid-frame: reset asserted after 300 pixels -> all outputs 0, state LATCH; the following full frame is correct.
- LFSR handshake: connect the LFSR block and run 3 frames -> scale_i sampled in LATCH equals the LFSR value after each rnd_advance_o.

Source files
------------

// File: rtl/resized_crop_pkg.sv
// Shared types and constants for the random resized-crop stream block:
// FSM state encoding, crop-size lookup table and accumulator width.
package resized_crop_pkg;

    typedef enum logic [1:0] {
        ST_LATCH = 2'd0,
        ST_RUN   = 2'd1,
        ST_ADV   = 2'd2
    } crop_state_t;

    localparam int PKG_IMG_SIZE = 28;
    localparam int ACC_W        = $clog2(2 * PKG_IMG_SIZE);
    localparam int CROP_W       = 5;

    // Indexed by the LFSR scale code; the smallest entry must stay >= OUT_SIZE.
    localparam logic [CROP_W-1:0] CROP_SIZE [4] = '{5'd28, 5'd24, 5'd20, 5'd16};

    function automatic logic [CROP_W-1:0] clamp_offset(
        input logic [CROP_W-1:0] off,
        input logic [CROP_W-1:0] lim
    );
        logic [CROP_W-1:0] res;
        if (off > lim) begin
            res = lim;
        end else begin
            res = off;
        end
        return res;
    endfunction

endpackage

// File: rtl/resized_crop_stream_axis_sel.sv
// One-axis window test plus nearest-neighbour keep decision, driven by a
// Bresenham-style accumulator that lands the last window position on a keep.
module crop_axis_sel
    import resized_crop_pkg::*;
#(
    parameter int XY_W     = 5,
    parameter int OUT_SIZE = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_step,
    input  logic [XY_W-1:0]   i_offset,
    input  logic [CROP_W-1:0] i_crop,
    input  logic [XY_W-1:0]   i_pos,
    output logic              o_in_win,
    output logic              o_keep
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_pos;
    logic [ACC_W-1:0] w_lo;
    logic [ACC_W-1:0] w_hi;
    logic [ACC_W-1:0] w_crop;
    logic [ACC_W-1:0] w_sum;

    assign w_pos    = ACC_W'(i_pos);
    assign w_lo     = ACC_W'(i_offset);
    assign w_crop   = ACC_W'(i_crop);
    assign w_hi     = w_lo + w_crop;
    assign w_sum    = r_acc + ACC_W'(OUT_SIZE);
    assign o_in_win = (w_pos >= w_lo) && (w_pos < w_hi);
    assign o_keep   = (w_sum >= w_crop);

    // Accumulator: step on each in-window position, clear on request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= {ACC_W{1'b0}};
        end else if (i_clear) begin
            r_acc <= {ACC_W{1'b0}};
        end else if (i_step && o_in_win) begin
            if (o_keep) begin
                r_acc <= w_sum - w_crop;
            end else begin
                r_acc <= w_sum;
            end
        end else begin
            r_acc <= r_acc;
        end
    end

endmodule

// File: rtl/resized_crop_stream.sv
// Random resized crop on a raster pixel stream: latches crop size/offsets per
// frame, keeps an OUT_SIZE x OUT_SIZE subsample, and requests a new random code.
module resized_crop_stream
    import resized_crop_pkg::*;
#(
    parameter int IMG_SIZE = 28,
    parameter int OUT_SIZE = 16,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        scale_i,
    input  logic [4:0]        off_x_i,
    input  logic [4:0]        off_y_i,
    output logic              rnd_advance_o,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              frame_err_o
);

    localparam int              XY_W     = $clog2(IMG_SIZE);
    localparam logic [XY_W-1:0] LAST_POS = XY_W'(IMG_SIZE - 1);
    localparam logic [XY_W-1:0] XY_ONE   = {{(XY_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};

    crop_state_t        r_state;
    logic [CROP_W-1:0]  r_crop;
    logic [XY_W-1:0]    r_ox;
    logic [XY_W-1:0]    r_oy;
    logic [XY_W-1:0]    r_x;
    logic [XY_W-1:0]    r_y;
    logic               r_row_keep;
    logic               r_m_valid;
    logic [DATA_W-1:0]  r_m_data;
    logic               r_m_last;
    logic               r_rnd_adv;
    logic               r_frame_err;

    logic               w_s_ready;
    logic               w_accept;
    logic               w_x_end;
    logic               w_final;
    logic               w_row_start;
    logic               w_latch;
    logic               w_col_clear;
    logic               w_col_step;
    logic               w_row_step;
    logic               w_col_in;
    logic               w_col_keep;
    logic               w_row_in;
    logic               w_row_keep_raw;
    logic               w_row_keep;
    logic               w_keep;
    logic               w_out_last;
    logic [CROP_W-1:0]  w_lat_crop;
    logic [CROP_W-1:0]  w_off_lim;

    assign w_latch     = (r_state == ST_LATCH);
    assign w_s_ready   = (r_state == ST_RUN) && (!r_m_valid || m_ready);
    assign w_accept    = s_valid && w_s_ready;
    assign w_x_end     = (r_x == LAST_POS);
    assign w_final     = w_x_end && (r_y == LAST_POS);
    assign w_row_start = (r_x == r_ox);

    assign w_lat_crop  = CROP_SIZE[scale_i];
    assign w_off_lim   = CROP_W'(IMG_SIZE) - w_lat_crop;

    // Column accumulator restarts each raster row; the row one only per frame.
    assign w_col_clear = w_latch || (w_accept && w_x_end);
    assign w_col_step  = w_accept && w_row_in;
    assign w_row_step  = w_accept && w_row_start;

    crop_axis_sel #(
        .XY_W     (XY_W),
        .OUT_SIZE (OUT_SIZE)
    ) u_col_sel (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_col_clear),
        .i_step   (w_col_step),
        .i_offset (r_ox),
        .i_crop   (r_crop),
        .i_pos    (r_x),
        .o_in_win (w_col_in),
        .o_keep   (w_col_keep)
    );

    crop_axis_sel #(
        .XY_W     (XY_W),
        .OUT_SIZE (OUT_SIZE)
    ) u_row_sel (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_latch),
        .i_step   (w_row_step),
        .i_offset (r_oy),
        .i_crop   (r_crop),
        .i_pos    (r_y),
        .o_in_win (w_row_in),
        .o_keep   (w_row_keep_raw)
    );

    // The row decision is made at x==ox and then held for the rest of the row.
    assign w_row_keep = w_row_start ? w_row_keep_raw : r_row_keep;
    assign w_keep     = w_col_in && w_row_in && w_col_keep && w_row_keep;
    assign w_out_last = ((ACC_W'(r_x) + ACC_ONE) == (ACC_W'(r_ox) + ACC_W'(r_crop))) &&
                        ((ACC_W'(r_y) + ACC_ONE) == (ACC_W'(r_oy) + ACC_W'(r_crop)));

    // Frame FSM, position counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_LATCH;
            r_crop      <= {CROP_W{1'b0}};
            r_ox        <= {XY_W{1'b0}};
            r_oy        <= {XY_W{1'b0}};
            r_x         <= {XY_W{1'b0}};
            r_y         <= {XY_W{1'b0}};
            r_row_keep  <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= {DATA_W{1'b0}};
            r_m_last    <= 1'b0;
            r_rnd_adv   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rnd_adv   <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_accept && w_keep) begin
                r_m_valid <= 1'b1;
                r_m_data  <= s_data;
                r_m_last  <= w_out_last;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end

            case (r_state)
                ST_LATCH: begin
                    r_crop     <= w_lat_crop;
                    r_ox       <= XY_W'(clamp_offset(off_x_i, w_off_lim));
                    r_oy       <= XY_W'(clamp_offset(off_y_i, w_off_lim));
                    r_x        <= {XY_W{1'b0}};
                    r_y        <= {XY_W{1'b0}};
                    r_row_keep <= 1'b0;
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_accept) begin
                        if (w_row_start) begin
                            r_row_keep <= w_row_in && w_row_keep_raw;
                        end
                        if (s_last || w_final) begin
                            r_state     <= ST_ADV;
                            r_rnd_adv   <= 1'b1;
                            r_frame_err <= (s_last != w_final);
                        end else if (w_x_end) begin
                            r_x <= {XY_W{1'b0}};
                            r_y <= r_y + XY_ONE;
                        end else begin
                            r_x <= r_x + XY_ONE;
                        end
                    end
                end
                ST_ADV: begin
                    r_state <= ST_LATCH;
                end
                default: begin
                    r_state <= ST_LATCH;
                end
            endcase
        end
    end

    assign s_ready       = w_s_ready;
    assign m_valid       = r_m_valid;
    assign m_data        = r_m_data;
    assign m_last        = r_m_last;
    assign rnd_advance_o = r_rnd_adv;
    assign frame_err_o   = r_frame_err;

endmodule
